ksa: RTL and testbench

//  ARC4 key-scheduling stage. It runs after the S-array fill stage has written S[i]=i

---
 rtl/ksa.sv | 153 +++++++++++++++
 tb/tb_ksa.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ksa.sv
`default_nettype none
// ============================================================================
// Module  : ksa
// Purpose : ARC4 key-scheduling stage; permutes the shared 256x8 S memory in
//           place with the latched key, one 6-cycle iteration per index i.
// Rev     : 1.0  initial release
// ============================================================================
module ksa #(
    parameter int KEY_BYTES = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    output logic                   rdy,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic [7:0]             addr,
    input  logic [7:0]             rddata,
    output logic [7:0]             wrdata,
    output logic                   wren
);

    localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(KEY_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_I  = 3'd1,
        S_LAT_I = 3'd2,
        S_RD_J  = 3'd3,
        S_LAT_J = 3'd4,
        S_WR_I  = 3'd5,
        S_WR_J  = 3'd6
    } state_t;

    state_t                   state_q, state_d;
    logic [8*KEY_BYTES-1:0]   key_q, key_d;
    logic [7:0]               i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
    logic [KIDX_W-1:0]        kidx_q, kidx_d;
    logic [7:0]               addr_q, addr_d, wrdata_q, wrdata_d;
    logic                     wren_q, wren_d, rdy_q, rdy_d;
    logic [7:0]               keybyte;

    // Byte 0 is the most significant byte of the key.
    always_comb begin
        keybyte = key_q[8*KEY_BYTES-1 -: 8];
        for (int k = 0; k < KEY_BYTES; k++) begin
            if (kidx_q == KIDX_W'(k)) keybyte = key_q[8*(KEY_BYTES-k)-1 -: 8];
        end
    end

    // Outputs are computed one cycle ahead so they are registered in the state they belong to.
    always_comb begin
        state_d  = state_q;
        key_d    = key_q;
        i_d      = i_q;
        j_d      = j_q;
        si_d     = si_q;
        sj_d     = sj_q;
        kidx_d   = kidx_q;
        addr_d   = addr_q;
        wrdata_d = wrdata_q;
        wren_d   = 1'b0;
        rdy_d    = rdy_q;
        case (state_q)
            S_IDLE: begin
                if (en && rdy_q) begin
                    key_d   = key;
                    i_d     = 8'd0;
                    j_d     = 8'd0;
                    kidx_d  = '0;
                    rdy_d   = 1'b0;
                    addr_d  = 8'd0;
                    state_d = S_RD_I;
                end
            end
            S_RD_I:  state_d = S_LAT_I;
            S_LAT_I: begin
                si_d    = rddata;
                j_d     = j_q + rddata + keybyte;
                addr_d  = j_d;
                state_d = S_RD_J;
            end
            S_RD_J:  state_d = S_LAT_J;
            S_LAT_J: begin
                sj_d     = rddata;
                addr_d   = i_q;
                wrdata_d = rddata;
                wren_d   = 1'b1;
                state_d  = S_WR_I;
            end
            S_WR_I: begin
                addr_d   = j_q;
                wrdata_d = si_q;
                wren_d   = 1'b1;
                state_d  = S_WR_J;
            end
            S_WR_J: begin
                if (i_q == 8'd255) begin
                    addr_d   = 8'd0;
                    wrdata_d = 8'd0;
                    rdy_d    = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    i_d     = i_q + 8'd1;
                    kidx_d  = (kidx_q == KIDX_LAST) ? '0 : kidx_q + KIDX_W'(1);
                    addr_d  = i_q + 8'd1;
                    state_d = S_RD_I;
                end
            end
            default: begin
                addr_d   = 8'd0;
                wrdata_d = 8'd0;
                rdy_d    = 1'b1;
                state_d  = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            key_q    <= '0;
            i_q      <= 8'd0;
            j_q      <= 8'd0;
            si_q     <= 8'd0;
            sj_q     <= 8'd0;
            kidx_q   <= '0;
            addr_q   <= 8'd0;
            wrdata_q <= 8'd0;
            wren_q   <= 1'b0;
            rdy_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            i_q      <= i_d;
            j_q      <= j_d;
            si_q     <= si_d;
            sj_q     <= sj_d;
            kidx_q   <= kidx_d;
            addr_q   <= addr_d;
            wrdata_q <= wrdata_d;
            wren_q   <= wren_d;
            rdy_q    <= rdy_d;
        end
    end

    assign addr   = addr_q;
    assign wrdata = wrdata_q;
    assign wren   = wren_q;
    assign rdy    = rdy_q;

endmodule
`default_nettype wire

// File: tb/tb_ksa.sv
`default_nettype none
// ============================================================================
// Module  : tb_ksa
// Purpose : Self-checking bench for ksa against a software ARC4 KSA model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_ksa;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en3 = 1'b0, en1 = 1'b0;
    logic [23:0] key3 = '0;
    logic [7:0]  key1 = '0;
    logic        rdy3, rdy1, wren3, wren1;
    logic [7:0]  addr3, addr1, wrdata3, wrdata1;
    logic [7:0]  rddata3 = '0, rddata1 = '0;
    logic [7:0]  mem3 [256];
    logic [7:0]  mem1 [256];
    logic [7:0]  init_s [256];
    logic [7:0]  gold [256];
    logic        pl3 = 1'b0, pl1 = 1'b0;
    int          n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    ksa #(.KEY_BYTES(3)) dut (
        .clk(clk), .rst(rst), .en(en3), .rdy(rdy3), .key(key3),
        .addr(addr3), .rddata(rddata3), .wrdata(wrdata3), .wren(wren3)
    );

    ksa #(.KEY_BYTES(1)) dut1 (
        .clk(clk), .rst(rst), .en(en1), .rdy(rdy1), .key(key1),
        .addr(addr1), .rddata(rddata1), .wrdata(wrdata1), .wren(wren1)
    );

    // Synchronous RAMs, one per DUT, with a one-shot bulk preload.
    always @(posedge clk) begin
        if (pl3) for (int k = 0; k < 256; k++) mem3[k] <= init_s[k];
        else if (wren3) mem3[addr3] <= wrdata3;
        rddata3 <= mem3[addr3];
    end

    always @(posedge clk) begin
        if (pl1) for (int k = 0; k < 256; k++) mem1[k] <= init_s[k];
        else if (wren1) mem1[addr1] <= wrdata1;
        rddata1 <= mem1[addr1];
    end

    task automatic preload(input bit sel, input bit rnd);
        for (int k = 0; k < 256; k++) init_s[k] = rnd ? 8'($urandom) : 8'(k);
        @(negedge clk);
        if (sel) pl1 = 1'b1; else pl3 = 1'b1;
        @(negedge clk);
        pl1 = 1'b0;
        pl3 = 1'b0;
    endtask

    // Reference ARC4 key schedule on a copy of the preloaded array.
    task automatic gold_ksa(input logic [23:0] k, input int nb);
        int j, t;
        logic [7:0] kb;
        for (int n = 0; n < 256; n++) gold[n] = init_s[n];
        j = 0;
        for (int i = 0; i < 256; i++) begin
            kb = 8'((k >> (8 * (nb - 1 - (i % nb)))) & 24'hFF);
            j = (j + int'(gold[i]) + int'(kb)) % 256;
            t = int'(gold[i]);
            gold[i] = gold[j];
            gold[j] = 8'(t);
        end
    endtask

    function automatic int count_diff(input bit sel);
        int d = 0;
        for (int n = 0; n < 256; n++)
            if ((sel ? mem1[n] : mem3[n]) !== gold[n]) d++;
        return d;
    endfunction

    // Accepts one run and watches it until rdy returns (bounded).
    task automatic run(input bit sel, input logic [23:0] k, input bit hold,
                       input int chg_at, input logic [23:0] k2,
                       output int rdy_cyc, output int nw, output int fa,
                       output int fd, output logic r_first);
        logic r, w;
        logic [7:0] a, d;
        @(negedge clk);
        if (sel) begin key1 = k[7:0]; en1 = 1'b1; end
        else     begin key3 = k;      en3 = 1'b1; end
        rdy_cyc = -1; nw = 0; fa = -1; fd = -1; r_first = 1'bx;
        @(posedge clk);
        #1;
        if (!hold) begin en1 = 1'b0; en3 = 1'b0; end
        for (int c = 1; c <= 3000; c++) begin
            @(negedge clk);
            r = sel ? rdy1 : rdy3;
            w = sel ? wren1 : wren3;
            a = sel ? addr1 : addr3;
            d = sel ? wrdata1 : wrdata3;
            if (c == 1) r_first = r;
            if (c == chg_at) begin key3 = k2; key1 = k2[7:0]; end
            if (r === 1'b1) begin rdy_cyc = c; break; end
            if (w === 1'b1) begin
                if (nw == 0) begin fa = int'(a); fd = int'(d); end
                nw++;
            end
        end
        en1 = 1'b0;
        en3 = 1'b0;
    endtask

    task automatic test_reset();
        #3 rst = 1'b1;
        #1;
        n_tests++; if (rdy3 !== 1'b1) begin n_fail++; $display("FAIL reset_rdy: got %b expected 1", rdy3); end
        n_tests++; if (wren3 !== 1'b0) begin n_fail++; $display("FAIL reset_wren: got %b expected 0", wren3); end
        n_tests++; if (addr3 !== 8'd0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", addr3); end
        n_tests++; if (wrdata3 !== 8'd0) begin n_fail++; $display("FAIL reset_wrdata: got %0d expected 0", wrdata3); end
        n_tests++; if (rdy1 !== 1'b1) begin n_fail++; $display("FAIL reset_rdy_kb1: got %b expected 1", rdy1); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_zero_key();
        int rc, nw, fa, fd;
        logic r1;
        preload(1'b0, 1'b0);
        gold_ksa(24'h000000, 3);
        run(1'b0, 24'h000000, 1'b0, 0, 24'h0, rc, nw, fa, fd, r1);
        n_tests++; if (r1 !== 1'b0) begin n_fail++; $display("FAIL busy_after_accept: rdy got %b expected 0", r1); end
        n_tests++; if (rc != 1537) begin n_fail++; $display("FAIL rdy_latency: got %0d expected 1537", rc); end
        n_tests++; if (nw != 512) begin n_fail++; $display("FAIL wren_pulses: got %0d expected 512", nw); end
        n_tests++; if (fa != 0) begin n_fail++; $display("FAIL first_wr_addr: got %0d expected 0", fa); end
        n_tests++; if (fd != 0) begin n_fail++; $display("FAIL first_wr_data: got %0d expected 0", fd); end
        for (int n = 0; n < 4; n++) begin
            n_tests++;
            if (mem3[n] !== gold[n]) begin
                n_fail++; $display("FAIL zero_key_S[%0d]: got %0d expected %0d", n, mem3[n], gold[n]);
            end
        end
        n_tests++; if (count_diff(1'b0) != 0) begin n_fail++; $display("FAIL zero_key_array: got %0d bad entries expected 0", count_diff(1'b0)); end
    endtask

    task automatic test_keys();
        logic [23:0] keys [4];
        int rc, nw, fa, fd;
        logic r1;
        keys[0] = 24'h1E4600;
        keys[1] = 24'hFFFFFF;
        keys[2] = 24'($urandom);
        keys[3] = 24'($urandom);
        for (int t = 0; t < 4; t++) begin
            preload(1'b0, t >= 2);
            gold_ksa(keys[t], 3);
            run(1'b0, keys[t], 1'b0, 0, 24'h0, rc, nw, fa, fd, r1);
            n_tests++; if (rc != 1537) begin n_fail++; $display("FAIL key_%06h_latency: got %0d expected 1537", keys[t], rc); end
            n_tests++; if (count_diff(1'b0) != 0) begin n_fail++; $display("FAIL key_%06h_array: got %0d bad entries expected 0", keys[t], count_diff(1'b0)); end
        end
    endtask

    task automatic test_hold_en();
        logic [23:0] k;
        int rc, nw, fa, fd;
        logic r1;
        k = 24'($urandom);
        preload(1'b0, 1'b0);
        gold_ksa(k, 3);
        run(1'b0, k, 1'b1, 700, ~k, rc, nw, fa, fd, r1);
        n_tests++; if (rc != 1537) begin n_fail++; $display("FAIL hold_en_latency: got %0d expected 1537", rc); end
        n_tests++; if (count_diff(1'b0) != 0) begin n_fail++; $display("FAIL hold_en_array: got %0d bad entries expected 0", count_diff(1'b0)); end
    endtask

    task automatic test_async_reset();
        logic [23:0] k;
        int rc, nw, fa, fd, stray;
        logic r1;
        preload(1'b0, 1'b0);
        @(negedge clk);
        key3 = 24'($urandom);
        en3 = 1'b1;
        @(posedge clk);
        #1 en3 = 1'b0;
        repeat (605) @(negedge clk);
        n_tests++; if (wren3 !== 1'b1) begin n_fail++; $display("FAIL iter100_wr_i: wren got %b expected 1", wren3); end
        #2 rst = 1'b1;
        #1;
        n_tests++; if (rdy3 !== 1'b1) begin n_fail++; $display("FAIL async_rst_rdy: got %b expected 1", rdy3); end
        n_tests++; if (wren3 !== 1'b0) begin n_fail++; $display("FAIL async_rst_wren: got %b expected 0", wren3); end
        n_tests++; if (addr3 !== 8'd0) begin n_fail++; $display("FAIL async_rst_addr: got %0d expected 0", addr3); end
        stray = 0;
        repeat (3) begin @(negedge clk); if (wren3 !== 1'b0) stray++; end
        rst = 1'b0;
        repeat (3) begin @(negedge clk); if (wren3 !== 1'b0) stray++; end
        n_tests++; if (stray != 0) begin n_fail++; $display("FAIL post_rst_writes: got %0d expected 0", stray); end
        k = 24'($urandom);
        preload(1'b0, 1'b0);
        gold_ksa(k, 3);
        run(1'b0, k, 1'b0, 0, 24'h0, rc, nw, fa, fd, r1);
        n_tests++; if (rc != 1537) begin n_fail++; $display("FAIL rerun_latency: got %0d expected 1537", rc); end
        n_tests++; if (count_diff(1'b0) != 0) begin n_fail++; $display("FAIL rerun_array: got %0d bad entries expected 0", count_diff(1'b0)); end
    endtask

    task automatic test_key_bytes_1();
        logic [7:0] keys [2];
        int rc, nw, fa, fd;
        logic r1;
        keys[0] = 8'h01;
        keys[1] = 8'($urandom);
        for (int t = 0; t < 2; t++) begin
            preload(1'b1, t == 1);
            gold_ksa({16'h0, keys[t]}, 1);
            run(1'b1, {16'h0, keys[t]}, 1'b0, 0, 24'h0, rc, nw, fa, fd, r1);
            n_tests++; if (nw != 512) begin n_fail++; $display("FAIL kb1_%02h_wren_pulses: got %0d expected 512", keys[t], nw); end
            n_tests++; if (count_diff(1'b1) != 0) begin n_fail++; $display("FAIL kb1_%02h_array: got %0d bad entries expected 0", keys[t], count_diff(1'b1)); end
        end
    endtask

    initial begin
        test_reset();
        test_zero_key();
        test_keys();
        test_hold_en();
        test_async_reset();
        test_key_bytes_1();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
